// File: rtl/result_reader.sv
// result_reader: streams a block of result words out of a synchronous-read
// memory after the accelerator signals completion.
//
// A start pulse in IDLE latches the base address and word count. Reads are
// issued at base+index (wrapping at 2^ADDR_W) into a 2-entry FIFO, and the
// FIFO head is presented on a valid/ready stream with out_last on the final
// word. A one-cycle done pulse follows acceptance of the final beat.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    one-cycle readback request (honoured in IDLE only)
//   output_memory_offset     base address of the result block
//   result_count             number of words to stream (0 -> done, no beats)
//   mem_read_addr            memory address; holds when no read is issued
//   mem_read_data            memory data, valid one cycle after the address
//   out_data/valid/ready/last  result stream
//   busy, done               status
//
// Build option: define RESULT_READER_RELU_EN to clamp negative words
// (MSB set) to zero on out_data. Timing and beat count are unaffected.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads, streaming words
// DRAIN | all reads issued, emptying FIFO
// DONE  | one-cycle done pulse

module result_reader #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] output_memory_offset,
  input  logic [ADDR_W-1:0] result_count,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [DATA_W-1:0] fifo_data_d [2];
  logic [1:0]        fifo_last_q, fifo_last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              pop;
  logic              issue;
  logic              is_last;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] head_word;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign head_word = fifo_data_q[rd_ptr_q];

  // Occupancy counts the beat leaving this cycle, so a full-rate stream can
  // keep one read in flight while one word sits in the FIFO.
  assign occ        = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue      = (state_q == READ) && (occ < 2'd2);
  assign is_last    = (index_q == count_q - 1'b1);
  assign issue_addr = base_q + index_q;

  // The address is driven combinationally on the issue cycle so data can be
  // captured the next cycle; otherwise the last issued address is held.
  assign mem_read_addr = issue ? issue_addr : addr_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    index_d     = index_q;
    addr_d      = addr_q;
    inflight_d  = issue;
    infl_last_d = issue & is_last;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = mem_read_data;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = output_memory_offset;
          count_d = result_count;
          index_d = '0;
          state_d = (result_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d  = issue_addr;
          index_d = index_q + 1'b1;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_cnt_d == 2'd0) && !inflight_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      index_q        <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      infl_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      count_q        <= count_d;
      index_q        <= index_d;
      addr_q         <= addr_d;
      inflight_q     <= inflight_d;
      infl_last_q    <= infl_last_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_last_q    <= fifo_last_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef RESULT_READER_RELU_EN
      out_data = head_word[DATA_W-1] ? '0 : head_word;
`else
      out_data = head_word;
`endif
    end
  end

  assign out_last = out_valid & fifo_last_q[rd_ptr_q];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
